prom_shadow_loader: RTL and testbench
=====================================

Name: prom_shadow_loader

Overview:
- Upstream driver and consumer for a 32x8 bipolar PROM model (PROM_7112 / GENERIC_PROM family).
- After reset, or on START, it walks every PROM address and drives enable and address with cycle-counted setup to honour the PROM's tEN/tAA/tDIS.
- Each byte is captured into an internal shadow register file.
- The rest of the System86 video path reads PROM contents from the shadow synchronously, with 1-cycle latency, instead of through asynchronous PROM timing.

Parameters:
- ADDR_WIDTH, 5, PROM address width; shadow depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, PROM data width.
- EN_CYCLES, 1, clocks E is held active before the first address is sampled (covers tEN); minimum 1.
- WAIT_CYCLES, 2, clocks each address is held before Q is captured (covers tAA); minimum 1.
- DIS_CYCLES, 2, clocks after E deassert before DONE (covers tDIS); minimum 1.
- E_ACTIVE, 1'b1, logic level of PROM_E that enables the PROM.
- AUTO_LOAD, 1, 1 = start a load automatically on the first clock after reset release.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  single-cycle load request; honoured only in IDLE or DONE.
- PROM_E  output  1  PROM enable; equals E_ACTIVE only in ENABLE, ACCESS and CAPTURE.
- PROM_A  output  ADDR_WIDTH  PROM address, registered.
- PROM_Q  input  DATA_WIDTH  PROM data; X/Z is tolerated outside the capture cycle.
- BUSY  output  1  high while a load is in progress (any state other than IDLE or DONE).
- DONE  output  1  high in DONE: the shadow holds a complete image.
- RD_ADDR  input  ADDR_WIDTH  shadow read address.
- RD_DATA  output  DATA_WIDTH  shadow[RD_ADDR] registered on the rising edge (latency 1).

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - PROM_E = ~E_ACTIVE, PROM_A = 0, BUSY = 0, DONE = 0, RD_DATA = 0.
  - All shadow entries = 0; address and wait counters = 0.
- FSM states:
  - IDLE: leaves on START, or on the first clock after reset when AUTO_LOAD=1. On leaving, PROM_A <= 0, PROM_E <= E_ACTIVE, then ENABLE.
  - ENABLE: held EN_CYCLES clocks, then ACCESS.
  - ACCESS: held WAIT_CYCLES clocks at the current PROM_A, then CAPTURE.
  - CAPTURE: 1 clock. Writes shadow[PROM_A] <= PROM_Q.
    - If PROM_A != all-ones: PROM_A <= PROM_A+1, back to ACCESS.
    - Else: PROM_E <= ~E_ACTIVE, PROM_A stays all-ones, then DISABLE.
  - DISABLE: held DIS_CYCLES clocks, then DONE.
  - DONE: DONE=1, PROM_E inactive. START clears DONE and re-enters the IDLE-exit path (reload).
- Load length:
  - From the IDLE-exit edge to the first cycle with DONE=1 is exactly EN_CYCLES + 2**ADDR_WIDTH*(WAIT_CYCLES+1) + DIS_CYCLES clocks.
  - With defaults this is 1 + 32*3 + 2 = 99 clocks.
- BUSY and DONE are registered and never high together.
- PROM_A changes only on entry to ENABLE or on a CAPTURE edge. No address wrap occurs: the last address ends the walk.
- START while BUSY is ignored; it is not queued.
- Read port:
  - RD_DATA updates every clock regardless of state.
  - Reads during a load return the current shadow contents: 0 for entries not yet loaded.
  - A read and a CAPTURE write to the same address in the same cycle return the old value (read-before-write); the new value is visible one cycle later.
- RST asserted mid-load: the load aborts, shadow is zeroed, and PROM_E goes inactive immediately. With AUTO_LOAD=1 a fresh full load starts after release.
- Counter width: wait counter = clog2(max(EN,WAIT,DIS)+1) bits; it saturates to nothing, reloading on each state entry.

Test Plan:
- Reset/auto-load: PROM image Q = A ^ 8'hA5, defaults.
  - Release RST -> BUSY=1 the next cycle; DONE rises exactly 99 clocks after the IDLE exit, with BUSY=0 in the same cycle.
  - Then RD_ADDR=0..31 -> RD_DATA = A ^ 8'hA5 one cycle later, including addr 31 = 8'hBA.
- Timing compliance: PROM model with tAA=35ns at a 20ns clock and WAIT_CYCLES=2 -> every CAPTURE samples a settled, non-X Q.
  - Also check PROM_E is inactive throughout DISABLE and DONE.
- Mid-load reset: assert RST while PROM_A=16 -> PROM_E inactive, DONE=0 and RD_DATA of addr 5 = 0 immediately.
  - After release the reload completes with the correct image.
- START handling:
  - START while BUSY (PROM_A=8) -> ignored; load length is still 99.
  - START in DONE with the PROM image changed to A+1 -> DONE drops, and after reload RD_DATA(3) = 8'h04.
- Read/write collision: hold RD_ADDR=10 during a reload from an all-ones image (old content 8'hAF) -> RD_DATA=8'hAF on the capture edge, 8'hFF the next cycle.
- Parameter sweep: E_ACTIVE=0, EN=3, WAIT=1, DIS=1 -> PROM_E low only during the load.
  - Load length = 3 + 64 + 1 = 68 clocks; AUTO_LOAD=0 stays IDLE until START.

Source files
------------

// File: rtl/prom_shadow_loader.sv
// prom_shadow_loader: walks a bipolar PROM with cycle-counted E/A timing and
// mirrors every byte into a synchronously readable shadow register file.
`timescale 1ns/1ps
module prom_shadow_loader #(
  parameter int   ADDR_WIDTH  = 5,
  parameter int   DATA_WIDTH  = 8,
  parameter int   EN_CYCLES   = 1,
  parameter int   WAIT_CYCLES = 2,
  parameter int   DIS_CYCLES  = 2,
  parameter logic E_ACTIVE    = 1'b1,
  parameter bit   AUTO_LOAD   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  PROM_E,
  output logic [ADDR_WIDTH-1:0] PROM_A,
  input  logic [DATA_WIDTH-1:0] PROM_Q,
  output logic                  BUSY,
  output logic                  DONE,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int MAX_ED = (EN_CYCLES > DIS_CYCLES) ? EN_CYCLES : DIS_CYCLES;
  localparam int MAX_C  = (WAIT_CYCLES > MAX_ED) ? WAIT_CYCLES : MAX_ED;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] EN_LD   = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] DIS_LD  = CW'(DIS_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_ACCESS,
    S_CAPTURE,
    S_DISABLE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_auto;
  logic                  r_e;
  logic [ADDR_WIDTH-1:0] r_a;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  w_go;

  // r_auto is only live on the first clock after reset release
  assign w_go = ((r_state == S_IDLE) && (START || r_auto)) ||
                ((r_state == S_DONE) && START);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_auto  <= AUTO_LOAD;
      r_e     <= ~E_ACTIVE;
      r_a     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_auto <= 1'b0;
      if (w_go) begin
        r_state <= S_ENABLE;
        r_cnt   <= EN_LD;
        r_a     <= '0;
        r_e     <= E_ACTIVE;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else begin
        unique case (r_state)
          S_ENABLE: begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else begin
              r_state <= S_ACCESS;
              r_cnt   <= WAIT_LD;
            end
          end
          S_ACCESS: begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else r_state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            r_mem[r_a] <= PROM_Q;
            if (r_a != A_LAST) begin
              r_a     <= r_a + 1'b1;
              r_state <= S_ACCESS;
              r_cnt   <= WAIT_LD;
            end else begin
              r_e     <= ~E_ACTIVE;
              r_state <= S_DISABLE;
              r_cnt   <= DIS_LD;
            end
          end
          S_DISABLE: begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // read-before-write: a same-cycle capture shows up one clock later
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_rd <= '0;
    else     r_rd <= r_mem[RD_ADDR];
  end

  assign PROM_E  = r_e;
  assign PROM_A  = r_a;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign RD_DATA = r_rd;

endmodule

// File: tb/tb_prom_shadow_loader.sv
// tb_prom_shadow_loader: random-read checks of two loader configurations
// against timed PROM models and a cycle-indexed shadow reference.
`timescale 1ns/1ps
module tb_prom_shadow_loader;

  logic       clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst1, rst2, st1, st2;
  logic [4:0] ra1, ra2;
  logic       e1, e2, b1, b2, d1, d2;
  logic [4:0] a1, a2;
  logic [7:0] q1, q2, rd1, rd2;

  prom_shadow_loader dut (
    .CLK(clk), .RST(rst1), .START(st1),
    .PROM_E(e1), .PROM_A(a1), .PROM_Q(q1),
    .BUSY(b1), .DONE(d1),
    .RD_ADDR(ra1), .RD_DATA(rd1)
  );

  prom_shadow_loader #(
    .EN_CYCLES(3), .WAIT_CYCLES(1), .DIS_CYCLES(1),
    .E_ACTIVE(1'b0), .AUTO_LOAD(1'b0)
  ) dut2 (
    .CLK(clk), .RST(rst2), .START(st2),
    .PROM_E(e2), .PROM_A(a2), .PROM_Q(q2),
    .BUSY(b2), .DONE(d2),
    .RD_ADDR(ra2), .RD_DATA(rd2)
  );

  // PROM models: Q is X until 35 ns after any A/E change
  logic [7:0] img1 [32];
  logic [7:0] img2 [32];
  time t1 = 0, t2 = 0;
  always @(a1 or e1) t1 = $time;
  always @(a2 or e2) t2 = $time;
  initial forever begin
    #1;
    q1 = (e1 === 1'b1 && ($time - t1) >= 35) ? img1[a1] : 8'hxx;
    q2 = (e2 === 1'b0 && ($time - t2) >= 35) ? img2[a2] : 8'hxx;
  end

  logic [7:0] sh1 [32];
  logic [7:0] sh2 [32];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit u, input bit by_start,
                         input int en, input int w, input int dis,
                         input int ra_fix, input int inj_a);
    logic [7:0] nw [32];
    logic [7:0] old [32];
    int n, cap, ra, bad_e, bad_bd, walk;
    bit inj, eact;
    eact = u ? 1'b0 : 1'b1;
    walk = en + 32 * (w + 1);
    for (int k = 0; k < 32; k++) begin
      nw[k]  = u ? img2[k] : img1[k];
      old[k] = u ? sh2[k] : sh1[k];
    end
    if (by_start) begin
      if (u) st2 = 1'b1;
      else   st1 = 1'b1;
    end
    tick;
    st1 = 1'b0;
    st2 = 1'b0;
    chk("busy_after_exit", u ? b2 : b1, 1);
    chk("done_low_after_exit", u ? d2 : d1, 0);
    n = 0; bad_e = 0; bad_bd = 0; inj = 0;
    while (!(u ? d2 : d1) && n < 500) begin
      ra = (ra_fix >= 0) ? ra_fix : int'($urandom_range(0, 31));
      if (u) ra2 = 5'(ra);
      else   ra1 = 5'(ra);
      if (!inj && inj_a >= 0 && (u ? a2 : a1) == inj_a) begin
        inj = 1;
        if (u) st2 = 1'b1;
        else   st1 = 1'b1;
      end
      tick;
      st1 = 1'b0;
      st2 = 1'b0;
      n++;
      cap = en + (ra + 1) * (w + 1);
      chk("rd_during_load", u ? rd2 : rd1,
          (n - 1 >= cap) ? nw[ra] : old[ra]);
      if ((u ? e2 : e1) !== ((n < walk) ? eact : ~eact)) bad_e++;
      if ((u ? b2 : b1) && (u ? d2 : d1)) bad_bd++;
    end
    chk("load_len", n, walk + dis);
    chk("busy_at_done", u ? b2 : b1, 0);
    chk("e_window", bad_e, 0);
    chk("busy_done_excl", bad_bd, 0);
    if (inj_a >= 0) chk("start_injected", inj, 1);
    for (int k = 0; k < 32; k++) begin
      if (u) sh2[k] = nw[k];
      else   sh1[k] = nw[k];
    end
  endtask

  task automatic readback(input bit u, input string tag);
    for (int a = 0; a < 32; a++) begin
      if (u) ra2 = 5'(a);
      else   ra1 = 5'(a);
      tick;
      chk(tag, u ? rd2 : rd1, u ? sh2[a] : sh1[a]);
    end
  endtask

  initial begin
    int n;
    rst1 = 1'b1; rst2 = 1'b1;
    st1 = 1'b0;  st2 = 1'b0;
    ra1 = '0;    ra2 = '0;
    for (int k = 0; k < 32; k++) begin
      img1[k] = 8'(k) ^ 8'hA5;
      img2[k] = 8'($urandom);
      sh1[k]  = '0;
      sh2[k]  = '0;
    end
    repeat (3) tick;
    chk("rst_e", e1, 0);
    chk("rst_a", a1, 0);
    chk("rst_busy", b1, 0);
    chk("rst_done", d1, 0);
    chk("rst_rd", rd1, 0);
    chk("rst_e2", e2, 1);

    rst1 = 1'b0; rst2 = 1'b0;
    do_load(0, 0, 1, 2, 2, -1, -1);
    readback(0, "img_a5");
    ra1 = 5'd31;
    tick;
    chk("rd31_BA", rd1, 8'hBA);

    // mid-load reset at address 16
    st1 = 1'b1;
    tick;
    st1 = 1'b0;
    n = 0;
    while (a1 != 5'd16 && n < 200) begin
      tick;
      n++;
    end
    chk("reached_a16", a1, 16);
    rst1 = 1'b1;
    #1;
    chk("midrst_e", e1, 0);
    chk("midrst_done", d1, 0);
    chk("midrst_busy", b1, 0);
    chk("midrst_rd", rd1, 0);
    ra1 = 5'd5;
    tick;
    chk("midrst_rd5", rd1, 0);
    for (int k = 0; k < 32; k++) sh1[k] = '0;
    rst1 = 1'b0;
    do_load(0, 0, 1, 2, 2, -1, -1);
    readback(0, "reload_after_rst");

    do_load(0, 1, 1, 2, 2, -1, 8);

    for (int k = 0; k < 32; k++) img1[k] = 8'hFF;
    do_load(0, 1, 1, 2, 2, 10, -1);

    for (int k = 0; k < 32; k++) img1[k] = 8'(k + 1);
    do_load(0, 1, 1, 2, 2, -1, -1);
    readback(0, "img_plus1");
    ra1 = 5'd3;
    tick;
    chk("rd3_04", rd1, 8'h04);

    for (int k = 0; k < 32; k++) img1[k] = 8'($urandom);
    do_load(0, 1, 1, 2, 2, -1, -1);
    readback(0, "img_rand");

    chk("d2_idle_busy", b2, 0);
    chk("d2_idle_done", d2, 0);
    chk("d2_idle_e", e2, 1);
    do_load(1, 1, 3, 1, 1, -1, -1);
    readback(1, "d2_img");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
